// File: rtl/spi_pkg.sv
// Shared SPI constants and helpers.
// Used by the receive shifter and the transmit sequencer.
package spi_pkg;

  localparam logic SPI_EDGE_FALL = 1'b0;
  localparam logic SPI_EDGE_RISE = 1'b1;

  function automatic int spi_bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Serial clock edge detector with optional 2-flop synchroniser.
// Define SPI_RX_SYNC_EN to synchronise serclk and ser_in to clk.
module spi_edge_det
  import spi_pkg::*;
#(
  parameter logic SAMPLE_RISE = SPI_EDGE_FALL,
  parameter logic CLK_IDLE    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic serclk,
  input  logic ser_in,
  output logic sample_ev,
  output logic din
);

  logic sclk_q;
  logic sclk_h;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] sclk_s;
  logic [1:0] din_s;

  // Data takes the same path as the clock so the two stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= {2{CLK_IDLE}};
      din_s  <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[0], serclk};
      din_s  <= {din_s[0], ser_in};
    end
  end

  assign sclk_q = sclk_s[1];
  assign din    = din_s[1];
`else
  assign sclk_q = serclk;
  assign din    = ser_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) sclk_h <= CLK_IDLE;
    else       sclk_h <= sclk_q;
  end

  assign sample_ev = (sclk_q != sclk_h) &&
                     (sclk_q == SAMPLE_RISE);

endmodule

// File: rtl/spi_rx_shift.sv
// Oversampled SPI receive shifter with holding register and tri-state read port.
// Optional input synchroniser enabled by SPI_RX_SYNC_EN.
module spi_rx_shift
  import spi_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter logic MSB_FIRST   = 1'b1,
  parameter logic SAMPLE_RISE = SPI_EDGE_FALL,
  parameter logic CLK_IDLE    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serclk,
  input  logic             ser_in,
  input  logic             enable,
  input  logic             data_rq,
  output logic [WIDTH-1:0] data,
  output logic             rx_valid,
  output logic             overrun,
  output logic             word_strobe
);

  localparam int BW = spi_bitcnt_w(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic             sample_ev;
  logic             din;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;
  logic [WIDTH-1:0] hold;
  logic [BW-1:0]    bitcnt;
  logic             rq_d;
  logic             read_start;
  logic             shift_en;
  logic             done;

  spi_edge_det #(
    .SAMPLE_RISE (SAMPLE_RISE),
    .CLK_IDLE    (CLK_IDLE)
  ) u_edge (
    .clk       (clk),
    .reset     (reset),
    .serclk    (serclk),
    .ser_in    (ser_in),
    .sample_ev (sample_ev),
    .din       (din)
  );

  always_comb begin
    if (MSB_FIRST) shift_nx = {shift[WIDTH-2:0], din};
    else           shift_nx = {din, shift[WIDTH-1:1]};
  end

  assign read_start = !data_rq && rq_d;
  assign shift_en   = enable && sample_ev;
  assign done       = shift_en && (bitcnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift       <= '0;
      hold        <= '0;
      bitcnt      <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      word_strobe <= 1'b0;
      rq_d        <= 1'b1;
    end else begin
      rq_d        <= data_rq;
      word_strobe <= done;
      if (!enable) begin
        bitcnt <= '0;
      end else if (sample_ev) begin
        shift <= shift_nx;
        if (done) begin
          hold   <= shift_nx;
          bitcnt <= '0;
        end else begin
          bitcnt <= bitcnt + BW'(1);
        end
      end
      // A completed word wins over a read that starts in the same cycle
      if (done)            rx_valid <= 1'b1;
      else if (read_start) rx_valid <= 1'b0;
      if (read_start)            overrun <= 1'b0;
      else if (done && rx_valid) overrun <= 1'b1;
    end
  end

  assign data = data_rq ? {WIDTH{1'bz}} : hold;

endmodule

// File: tb/tb_spi_rx_shift.sv
// Self-checking bench for spi_rx_shift.
// Covers both synchroniser builds via SPI_RX_SYNC_EN.
module tb_spi_rx_shift;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        serclk1, ser_in1, enable1, data_rq1;
  logic [7:0]  data1;
  logic        rx_valid1, overrun1, word_strobe1;
  logic        serclk2, ser_in2, enable2, data_rq2;
  logic [11:0] data2;
  logic        rx_valid2, overrun2, word_strobe2;

  int n_cmp = 0;
  int n_bad = 0;
  int s1_cnt = 0;
  int s2_cnt = 0;
  logic [7:0] last_exp = 8'h00;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_rx_shift dut1 (
    .clk         (clk),
    .reset       (reset),
    .serclk      (serclk1),
    .ser_in      (ser_in1),
    .enable      (enable1),
    .data_rq     (data_rq1),
    .data        (data1),
    .rx_valid    (rx_valid1),
    .overrun     (overrun1),
    .word_strobe (word_strobe1)
  );

  spi_rx_shift #(
    .WIDTH       (12),
    .MSB_FIRST   (1'b0),
    .SAMPLE_RISE (1'b1)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .serclk      (serclk2),
    .ser_in      (ser_in2),
    .enable      (enable2),
    .data_rq     (data_rq2),
    .data        (data2),
    .rx_valid    (rx_valid2),
    .overrun     (overrun2),
    .word_strobe (word_strobe2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each strobe consumes one expected word
  always @(posedge clk) begin
    #2;
    if (word_strobe1) begin
      s1_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL strobe1: unexpected word, none queued");
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    if (word_strobe2) s2_cnt++;
  end

  task automatic send_bit(input int sel, input logic b, input logic gl);
    if (sel == 1) begin
      ser_in1 = b;
      repeat (4) tick();
      serclk1 = 1'b0;
      repeat (8) tick();
      serclk1 = 1'b1;
      repeat (4) tick();
    end else begin
      ser_in2 = gl ? ~b : b;
      repeat (4) tick();
      serclk2 = 1'b0;
      repeat (4) tick();
      ser_in2 = b;
      repeat (4) tick();
      serclk2 = 1'b1;
      repeat (4) tick();
    end
  endtask

  task automatic send_word1(input logic [7:0] w);
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) send_bit(1, w[i], 1'b0);
  endtask

  task automatic read1(input string nm);
    data_rq1 = 1'b0;
    #1;
    chk({nm, "_data"}, {24'h0, data1}, {24'h0, last_exp});
    chk({nm, "_vld_hold"}, {31'h0, rx_valid1}, 32'd1);
    tick();
    chk({nm, "_vld_clr"}, {31'h0, rx_valid1}, 32'd0);
    chk({nm, "_ovr_clr"}, {31'h0, overrun1}, 32'd0);
    data_rq1 = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [7:0] word;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int s0;
    logic [7:0] w;
    logic [11:0] w2;

    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0};

    reset = 1'b1;
    serclk1 = 1'b1; ser_in1 = 1'b0; enable1 = 1'b1; data_rq1 = 1'b0;
    serclk2 = 1'b1; ser_in2 = 1'b0; enable2 = 1'b1; data_rq2 = 1'b0;
    repeat (3) tick();
    chk("rst_data1", {24'h0, data1}, 32'h0);
    chk("rst_data2", {20'h0, data2}, 32'h0);
    chk("rst_valid", {31'h0, rx_valid1}, 32'd0);
    chk("rst_ovr", {31'h0, overrun1}, 32'd0);
    chk("rst_strobe", {31'h0, word_strobe1}, 32'd0);
    reset = 1'b0;
    data_rq1 = 1'b1;
    data_rq2 = 1'b1;
    #1;
    chk("data1_z", {31'h0, data1 === 8'hzz}, 32'd1);
    chk("data2_z", {31'h0, data2 === 12'hzzz}, 32'd1);
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      send_word1(vecs[i].word);
      chk($sformatf("vec%0d_valid", i), {31'h0, rx_valid1},
          {31'h0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_ovr", i), {31'h0, overrun1},
          {31'h0, vecs[i].exp_ovr});
      read1($sformatf("vec%0d", i));
    end
    chk("vec_strobes", s1_cnt, 32'd4);

    send_word1(8'h11);
    send_word1(8'h22);
    chk("ovr_set", {31'h0, overrun1}, 32'd1);
    chk("ovr_valid", {31'h0, rx_valid1}, 32'd1);
    read1("ovr");

    s0 = s1_cnt;
    for (int i = 0; i < 5; i++) send_bit(1, 1'b1, 1'b0);
    enable1 = 1'b0;
    repeat (4) tick();
    enable1 = 1'b1;
    repeat (2) tick();
    chk("part_nostrobe", s1_cnt - s0, 32'd0);
    send_word1(8'h5A);
    chk("part_strobes", s1_cnt - s0, 32'd1);
    read1("part");

    w = 8'h96;
    exp_q.push_back(w);
    for (int i = 7; i > 0; i--) send_bit(1, w[i], 1'b0);
    ser_in1 = w[0];
    repeat (4) tick();
    serclk1 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (word_strobe1) break;
    end
    chk("latency", n, 1 + LAT);
    repeat (6) tick();
    serclk1 = 1'b1;
    repeat (4) tick();
    read1("lat");

    send_word1(8'h77);
    send_word1(8'h88);
    chk("coll_pre_ovr", {31'h0, overrun1}, 32'd1);
    w = 8'hC3;
    exp_q.push_back(w);
    for (int i = 7; i > 0; i--) send_bit(1, w[i], 1'b0);
    ser_in1 = w[0];
    repeat (4) tick();
    serclk1 = 1'b0;
    repeat (LAT) tick();
    data_rq1 = 1'b0;
    tick();
    chk("coll_data", {24'h0, data1}, 32'hC3);
    chk("coll_valid", {31'h0, rx_valid1}, 32'd1);
    chk("coll_ovr", {31'h0, overrun1}, 32'd0);
    repeat (4) tick();
    serclk1 = 1'b1;
    data_rq1 = 1'b1;
    repeat (4) tick();
    read1("coll");

    w2 = 12'h3C1;
    for (int i = 0; i < 12; i++) send_bit(2, w2[i], 1'b1);
    chk("w12_strobes", s2_cnt, 32'd1);
    chk("w12_valid", {31'h0, rx_valid2}, 32'd1);
    data_rq2 = 1'b0;
    #1;
    chk("w12_data", {20'h0, data2}, 32'h3C1);
    tick();
    chk("w12_vld_clr", {31'h0, rx_valid2}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_rx_shift.md
# spi_rx_shift

- Parametrised serial-to-parallel receive register for the MSB-side SPI breakout. Successor to the single-byte receive shifter.
- Runs on one system clock and oversamples the serial clock; it does not use the serial clock as a clock.
- Adds configurable word width, bit order and sample edge, word framing, a holding register, a valid/overrun handshake and a tri-state read port for the CPU data bus.
- Sits between the serial pins (driven by the transmit-side sequencer, which owns `enable`) and the bus decoder (which owns `data_rq`).

## Interface
- `WIDTH`, 8: bits per word, legal range 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in the MSB; 0 = first bit lands in the LSB.
- `SAMPLE_RISE`, 0: 0 = sample on falling `serclk` (legacy behaviour); 1 = sample on rising `serclk`.
- `CLK_IDLE`, 1: idle level of `serclk`; used as the reset value of the edge-detect history.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `serclk`  in  1  serial clock, asynchronous to `clk`; at least 4 `clk` periods per level.
- `ser_in`  in  1  serial data, stable around the sample edge of `serclk`.
- `enable`  in  1  active-high frame enable.
- `data_rq`  in  1  active-low read request.
- `data`  out  WIDTH  holding register when `data_rq`=0; high-Z otherwise.
- `rx_valid`  out  1  the holding register contains an unread word.
- `overrun`  out  1  sticky flag: a word completed while `rx_valid` was already 1.
- `word_strobe`  out  1  one-`clk` pulse on the cycle a word is transferred to the holding register.

## Operation
- Edge detect: `sclk_q` holds the (synchronised) `serclk`. A sample event is the cycle in which `sclk_q` differs from its previous value and equals `SAMPLE_RISE`.
- Shift on a sample event while `enable`=1:
  - `MSB_FIRST`=1: `shift <= {shift[WIDTH-2:0], din}`.
  - `MSB_FIRST`=0: `shift <= {din, shift[WIDTH-1:1]}`.
  - `bitcnt` increments; it is `$clog2(WIDTH+1)` bits wide.
- Word complete: on the sample event that brings `bitcnt` to `WIDTH`:
  - the holding register loads the new value (including the bit arriving that cycle);
  - `bitcnt` returns to 0;
  - `word_strobe`=1 and `rx_valid`=1;
  - if `rx_valid` was already 1, `overrun` is set.
- `enable`=0: `bitcnt` is forced to 0 and sample events are ignored. `shift` keeps its contents.
  - A partial word is discarded, and the next frame starts at bit 0.
  - The holding register, `rx_valid` and `overrun` are unaffected.
- Read:
  - The first cycle with `data_rq`=0 after a cycle with `data_rq`=1 is the read-start.
  - Read-start clears `rx_valid` and `overrun` at the end of that cycle.
  - `data` is driven for the whole time `data_rq`=0.
- Word completion in the same cycle as read-start:
  - the new word is loaded;
  - `rx_valid` stays 1;
  - `overrun` is cleared and not set.
- `serclk` edges that are not sample events (the opposite edge) have no effect.

## Timing
- Reset values: `shift`=0, holding register=0, `bitcnt`=0, `rx_valid`=0, `overrun`=0, `word_strobe`=0, edge history=`CLK_IDLE`.
  - `data` is 0 if `data_rq`=0 during reset, Z otherwise.
  - Reset takes priority over every other event.
  - Reset mid-frame discards the partial word.
- With sync (see Configuration): a `serclk` pin edge produces its sample event 2 `clk` cycles later.
  - `ser_in` passes through an identical 2-flop path, so data and clock stay aligned.
- Word latency: the holding register, `rx_valid` and `word_strobe` update on the same `clk` edge as the last shift.
- `data_rq` read-start is detected with 1 `clk` of history. `data` output is combinational from the holding register and `data_rq`, with no register delay.
- `word_strobe` is high for exactly one cycle per word, and never for a discarded partial word.

## Configuration
- `SPI_RX_SYNC_EN`, when defined: `serclk` and `ser_in` each pass through a 2-flop synchroniser (reset values `CLK_IDLE` and 0) before edge detection.
- When undefined: the pins feed edge detection directly, with zero added latency. Use this only when the sources are already synchronous to `clk`.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_EDGE_FALL`=0 and `SPI_EDGE_RISE`=1 constants;
  - a `spi_bitcnt_w(width)` function returning `$clog2(width+1)`, shared with the transmit sequencer.
- One natural sub-module: `spi_edge_det`. It contains the optional synchroniser plus the history flop, and outputs `sample_ev` and the aligned `din`. Its parameters are `SAMPLE_RISE` and `CLK_IDLE`.

## Test plan
- Reset, then with `data_rq`=0: `data`=8'h00, `rx_valid`=0, `overrun`=0. Raise `data_rq` and confirm `data`=Z.
- Default parameters: shift 8'hA5 MSB-first on falling edges with `enable`=1 -> `word_strobe` pulses once, `rx_valid`=1. Drop `data_rq` -> `data`=8'hA5, and `rx_valid`=0 on the next cycle.
- `WIDTH`=12, `MSB_FIRST`=0, `SAMPLE_RISE`=1: send bits of 12'h3C1 LSB-first -> `data`=12'h3C1. Opposite-edge glitches on `ser_in` change nothing.
- Two words 8'h11 and 8'h22 with no read between them -> `overrun`=1 and `data`=8'h22. Read-start clears both flags.
- Send 5 bits, drop `enable`, then send a full 8'h5A -> `data`=8'h5A, and `word_strobe` fires exactly once.
- Last bit of 8'hC3 arrives in the read-start cycle -> `data`=8'hC3, `rx_valid` stays 1, `overrun`=0. Also run with `SPI_RX_SYNC_EN` undefined and confirm the word is 2 cycles earlier.
